// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register code, stalls decode on
// RAW/overflow hazards, drives the register-file write port and supports pipeline drain.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        issueValid,
    input  logic        srcAValid,
    input  logic [3:0]  srcA,
    input  logic        srcBValid,
    input  logic [2:0]  srcB,
    input  logic        dstValid,
    input  logic [3:0]  dst,
    input  logic        wbValid,
    input  logic [3:0]  wbReg,
    input  logic [15:0] wbData,
    input  logic        drainReq,
    output logic        issueStall,
    output logic        drainDone,
    output logic        rfRegWrite,
    output logic [1:0]  rfWriteSpecReg,
    output logic [2:0]  rfR3,
    output logic [15:0] rfInData3,
    output logic [10:0] pendingMask,
    output logic [15:0] stallCount,
    output logic [1:0]  dbgState     // 0 = RUN, 1 = DRAIN, 2 = DONE
);

    localparam int NREG = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q [NREG];
    logic [CNT_W-1:0]  count_d [NREG];
    logic [CNT_W-1:0]  cnt_ext [16];
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic [3:0]        src_b_code;
    logic              haz_a, haz_b, haz_d;
    logic              issue_ok, all_zero_d;
    logic              inc, dec;

    // Codes 11-15 read as a zero count, so they can never hazard or pend.
    always_comb begin
        for (int i = 0; i < 16; i++) cnt_ext[i] = '0;
        for (int i = 0; i < NREG; i++) cnt_ext[i] = count_q[i];
    end

    assign src_b_code = {1'b0, srcB};

    // A writeback retiring the last in-flight write is bypassed via the falling-edge RF write.
    assign haz_a = srcAValid && (cnt_ext[srcA] != '0)
                   && !(wbValid && (wbReg == srcA) && (cnt_ext[srcA] == CNT_ONE));
    assign haz_b = srcBValid && (cnt_ext[src_b_code] != '0)
                   && !(wbValid && (wbReg == src_b_code) && (cnt_ext[src_b_code] == CNT_ONE));
    assign haz_d = dstValid && (cnt_ext[dst] == CNT_MAX) && !(wbValid && (wbReg == dst));

    assign issueStall = (state_q != ST_RUN) | drainReq | haz_a | haz_b | haz_d;
    assign issue_ok   = issueValid & ~issueStall;

    always_comb begin
        all_zero_d  = 1'b1;
        pendingMask = '0;
        inc         = 1'b0;
        dec         = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            inc = issue_ok && dstValid && (dst == 4'(i));
            dec = wbValid && (wbReg == 4'(i)) && (count_q[i] != '0);
            count_d[i] = count_q[i];
            if (inc && !dec) begin
                count_d[i] = count_q[i] + CNT_ONE;
            end else if (dec && !inc) begin
                count_d[i] = count_q[i] - CNT_ONE;
            end
            if (count_d[i] != '0) all_zero_d = 1'b0;
            pendingMask[i] = (count_q[i] != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drainReq) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drainReq) begin
                    state_d = ST_RUN;
                end else if (all_zero_d) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!drainReq) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issueValid && issueStall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            for (int i = 0; i < NREG; i++) count_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NREG; i++) count_q[i] <= count_d[i];
        end
    end

    assign drainDone  = (state_q == ST_DONE);
    assign stallCount = stall_cnt_q;
    assign dbgState   = state_q;

    assign rfRegWrite = wbValid & (wbReg <= 4'd10);
    assign rfR3       = wbReg[2:0];
    assign rfInData3  = wbData;

    always_comb begin
        case (wbReg)
            4'd8:    rfWriteSpecReg = 2'b01;
            4'd9:    rfWriteSpecReg = 2'b10;
            4'd10:   rfWriteSpecReg = 2'b11;
            default: rfWriteSpecReg = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: write-port vector table, directed hazard/drain/reset/saturation
// sequences, and a randomized run against a counting reference model.
module tb_reg_scoreboard;

  logic        CLK = 1'b0;
  logic        RST;
  logic        issueValid, srcAValid, srcBValid, dstValid, wbValid, drainReq;
  logic [3:0]  srcA, dst, wbReg;
  logic [2:0]  srcB;
  logic [15:0] wbData;
  logic        issueStall, drainDone, rfRegWrite;
  logic [1:0]  rfWriteSpecReg, dbgState;
  logic [2:0]  rfR3;
  logic [15:0] rfInData3, stallCount;
  logic [10:0] pendingMask;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  reg_scoreboard #(.CNT_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .issueValid(issueValid), .srcAValid(srcAValid), .srcA(srcA),
    .srcBValid(srcBValid), .srcB(srcB), .dstValid(dstValid), .dst(dst),
    .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData), .drainReq(drainReq),
    .issueStall(issueStall), .drainDone(drainDone), .rfRegWrite(rfRegWrite),
    .rfWriteSpecReg(rfWriteSpecReg), .rfR3(rfR3), .rfInData3(rfInData3),
    .pendingMask(pendingMask), .stallCount(stallCount), .dbgState(dbgState)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issueValid = 0; srcAValid = 0; srcA = 0; srcBValid = 0; srcB = 0;
    dstValid = 0; dst = 0; wbValid = 0; wbReg = 0; wbData = 0; drainReq = 0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    tick();
    tick();
    RST = 0;
    tick();
  endtask

  task automatic issue_dst(input logic [3:0] d);
    idle();
    issueValid = 1; dstValid = 1; dst = d;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_RUN, M_DRAIN, M_DONE} m_state_t;
  int       m_cnt [16];
  m_state_t m_state;
  int       m_stalls;
  logic [50:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_state  = M_RUN;
    m_stalls = 0;
  endfunction

  function automatic bit m_src_haz(input bit v, input int code);
    if (!v || code > 10 || m_cnt[code] == 0) return 0;
    if (wbValid && int'(wbReg) == code && m_cnt[code] == 1) return 0;
    return 1;
  endfunction

  function automatic bit m_stall();
    bit hd;
    hd = dstValid && int'(dst) <= 10 && m_cnt[dst] == 3 && !(wbValid && wbReg == dst);
    return (m_state != M_RUN) || drainReq || m_src_haz(srcAValid, int'(srcA))
           || m_src_haz(srcBValid, int'(srcB)) || hd;
  endfunction

  function automatic logic [50:0] model_outputs();
    logic [10:0] mask;
    logic        we;
    logic [1:0]  spec;
    for (int i = 0; i < 11; i++) mask[i] = (m_cnt[i] != 0);
    we   = wbValid && wbReg <= 10;
    spec = (we && wbReg >= 8) ? 2'(int'(wbReg) - 7) : 2'd0;
    return {m_stall(), (m_state == M_DONE), we, spec, wbReg[2:0], wbData, mask, 16'(m_stalls)};
  endfunction

  function automatic void model_step();
    bit stall, accept;
    int total;
    int w;
    stall  = m_stall();
    accept = issueValid && !stall;
    w      = int'(wbReg);
    if (wbValid && w <= 10 && m_cnt[w] > 0) m_cnt[w] = m_cnt[w] - 1;
    if (accept && dstValid && int'(dst) <= 10) m_cnt[dst] = m_cnt[dst] + 1;
    total = 0;
    for (int i = 0; i < 16; i++) total += m_cnt[i];
    if (issueValid && stall && m_stalls < 65535) m_stalls++;
    case (m_state)
      M_RUN:   if (drainReq) m_state = M_DRAIN;
      M_DRAIN: if (!drainReq) m_state = M_RUN; else if (total == 0) m_state = M_DONE;
      M_DONE:  if (!drainReq) m_state = M_RUN;
      default: m_state = M_RUN;
    endcase
  endfunction

  // ---------------- write-port vector table ----------------
  typedef struct {
    logic        wb_v;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        exp_we;
    logic [1:0]  exp_spec;
    logic [2:0]  exp_r3;
  } vec_t;

  vec_t vecs [8];

  // ---------------- test sequence ----------------
  initial begin
    logic [50:0] act, exp;
    vecs[0] = '{1'b1, 4'd10, 16'hBEEF, 1'b1, 2'b11, 3'd2};
    vecs[1] = '{1'b1, 4'd12, 16'h1234, 1'b0, 2'b00, 3'd4};
    vecs[2] = '{1'b1, 4'd0,  16'h0001, 1'b1, 2'b00, 3'd0};
    vecs[3] = '{1'b1, 4'd7,  16'hA5A5, 1'b1, 2'b00, 3'd7};
    vecs[4] = '{1'b1, 4'd8,  16'h5A5A, 1'b1, 2'b01, 3'd0};
    vecs[5] = '{1'b1, 4'd9,  16'hFFFF, 1'b1, 2'b10, 3'd1};
    vecs[6] = '{1'b1, 4'd15, 16'h0F0F, 1'b0, 2'b00, 3'd7};
    vecs[7] = '{1'b0, 4'd3,  16'h3333, 1'b0, 2'b00, 3'd3};

    do_reset();
    check("reset_mask", pendingMask, 0);
    check("reset_state", dbgState, 0);
    check("reset_stallcnt", stallCount, 0);
    check("reset_drainDone", drainDone, 0);

    // RAW hazard with same-cycle writeback bypass
    issue_dst(3);
    settle(); check("raw_dst_accept", issueStall, 0);
    tick();
    idle(); issueValid = 1; srcAValid = 1; srcA = 3;
    settle(); check("raw_stall", issueStall, 1);
    check("raw_mask", pendingMask, 11'h008);
    tick();
    check("raw_stallcnt", stallCount, 1);
    wbValid = 1; wbReg = 3;
    settle(); check("raw_bypass", issueStall, 0);
    tick();
    check("raw_mask_clear", pendingMask, 0);
    check("raw_stallcnt_hold", stallCount, 1);

    // counter saturation on IH
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_dst(9);
      settle(); check("sat_accept", issueStall, 0);
      tick();
    end
    issue_dst(9);
    settle(); check("sat_fourth_stall", issueStall, 1);
    tick();
    wbValid = 1; wbReg = 9;
    settle(); check("sat_fourth_wb_accept", issueStall, 0);
    tick();
    issue_dst(9);
    settle(); check("sat_still_full", issueStall, 1);
    idle(); wbValid = 1; wbReg = 9;
    tick(); tick();
    check("sat_two_left", pendingMask, 11'h200);
    tick();
    check("sat_drained", pendingMask, 0);

    // drain handshake
    do_reset();
    issue_dst(2);
    tick();
    idle(); drainReq = 1; issueValid = 1;
    settle(); check("drain_req_stall", issueStall, 1);
    tick();
    check("drain_state", dbgState, 1);
    check("drain_not_done", drainDone, 0);
    wbValid = 1; wbReg = 2;
    tick();
    check("drain_done", drainDone, 1);
    check("drain_state_done", dbgState, 2);
    idle(); issueValid = 1;
    settle(); check("done_stall", issueStall, 1);
    tick();
    check("drain_back_run", dbgState, 0);
    check("drain_done_clear", drainDone, 0);
    check("run_no_stall", issueStall, 0);

    // write-port table and ignored codes
    do_reset();
    issue_dst(12);
    tick();
    check("dst12_ignored", pendingMask, 0);
    for (int i = 0; i < 8; i++) begin
      idle();
      wbValid = vecs[i].wb_v; wbReg = vecs[i].wb_reg; wbData = vecs[i].wb_data;
      settle();
      check($sformatf("vec%0d_we", i), rfRegWrite, vecs[i].exp_we);
      if (vecs[i].exp_we) check($sformatf("vec%0d_spec", i), rfWriteSpecReg, vecs[i].exp_spec);
      check($sformatf("vec%0d_r3", i), rfR3, vecs[i].exp_r3);
      check($sformatf("vec%0d_data", i), rfInData3, vecs[i].wb_data);
      tick();
    end
    check("vec_no_count_change", pendingMask, 0);

    // asynchronous reset in the middle of a drain
    do_reset();
    issue_dst(1); tick();
    issue_dst(5); tick();
    idle(); drainReq = 1; issueValid = 1;
    tick(); tick();
    check("mid_drain_state", dbgState, 1);
    check("mid_drain_mask", pendingMask, 11'h022);
    check("mid_drain_stallcnt", stallCount, 2);
    #2 RST = 1;
    #1;
    check("async_rst_mask", pendingMask, 0);
    check("async_rst_state", dbgState, 0);
    check("async_rst_stallcnt", stallCount, 0);
    check("async_rst_drainDone", drainDone, 0);
    drainReq = 0; srcAValid = 1; srcA = 1; wbValid = 1; wbReg = 9;
    #1;
    check("rst_comb_stall", issueStall, 0);
    check("rst_comb_we", rfRegWrite, 1);
    check("rst_comb_spec", rfWriteSpecReg, 2'b10);
    drainReq = 1;
    #1;
    check("rst_comb_drain_stall", issueStall, 1);
    idle();
    @(negedge CLK);
    RST = 0;
    tick();

    // stall counter saturation
    do_reset();
    issue_dst(4); tick();
    idle(); issueValid = 1; srcAValid = 1; srcA = 4;
    repeat (65534) tick();
    check("stallcnt_fffe", stallCount, 16'hFFFE);
    repeat (6) tick();
    check("stallcnt_sat", stallCount, 16'hFFFF);

    // randomized run against the model
    do_reset();
    model_reset();
    drainReq = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 99) < 3) drainReq = ~drainReq;
      issueValid = ($urandom_range(0, 99) < 70);
      srcAValid  = $urandom_range(0, 1);
      srcA       = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      srcBValid  = $urandom_range(0, 1);
      srcB       = 3'($urandom_range(0, 4));
      dstValid   = ($urandom_range(0, 99) < 80);
      dst        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 3));
      wbValid    = ($urandom_range(0, 99) < 45);
      wbReg      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 3));
      wbData     = 16'($urandom);
      settle();
      exp_q.push_back(model_outputs());
      act = {issueStall, drainDone, rfRegWrite, (rfRegWrite ? rfWriteSpecReg : 2'd0), rfR3,
             rfInData3, pendingMask, stallCount};
      exp = exp_q.pop_front();
      check($sformatf("rand_cyc%0d", c), act, exp);
      model_step();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
